// File: rtl/vram_ctrl_pkg.sv
// Shared definitions for the fast VRAM initiator: bus widths, counter width,
// default strobe timing, FSM encoding and the per-state strobe decode.
package vram_ctrl_pkg;

  localparam int VRAM_AW       = 11;
  localparam int VRAM_DW       = 8;
  localparam int CNT_W         = 4;
  localparam int RD_CYCLES_DEF = 2;
  localparam int WR_CYCLES_DEF = 1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_WR_SETUP = 3'd2,
    ST_WR_PULSE = 3'd3,
    ST_WR_HOLD  = 3'd4
  } state_t;

  // SRAM pin strobes plus the data-bus drive enable, all active as named.
  typedef struct packed {
    logic nce;
    logic noe;
    logic nwe;
    logic doe;
  } strb_t;

  localparam strb_t STRB_IDLE = '{nce: 1'b1, noe: 1'b1, nwe: 1'b1, doe: 1'b0};

  // Pin levels wanted while sitting in state s. nOE is only ever low in RD,
  // and RD never drives the bus, so output-enable and write drive can't overlap.
  function automatic strb_t strb_of(state_t s);
    strb_t r;
    r = STRB_IDLE;
    case (s)
      ST_RD: begin
        r.nce = 1'b0;
        r.noe = 1'b0;
      end
      ST_WR_SETUP, ST_WR_HOLD: begin
        r.nce = 1'b0;
        r.doe = 1'b1;
      end
      ST_WR_PULSE: begin
        r.nce = 1'b0;
        r.nwe = 1'b0;
        r.doe = 1'b1;
      end
      default: r = STRB_IDLE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/vram_fast_ctrl.sv
// Synchronous initiator for a 2048x8 asynchronous fast SRAM. Converts a
// REQ/READY handshake into sequenced nCE/nOE/nWE, address and tri-state data.
// Strobes come straight from flops so the SRAM pins never see decode glitches.
module vram_fast_ctrl
  import vram_ctrl_pkg::*;
#(
  parameter int RD_CYCLES = RD_CYCLES_DEF,
  parameter int WR_CYCLES = WR_CYCLES_DEF
) (
  input  logic               CLK,
  input  logic               nRESET,
  input  logic               REQ,
  input  logic               RW,
  input  logic [VRAM_AW-1:0] REQ_ADDR,
  input  logic [VRAM_DW-1:0] WDATA,
  output logic               READY,
  output logic [VRAM_DW-1:0] RDATA,
  output logic               RDATA_VALID,
  output logic [VRAM_AW-1:0] ADDR,
  inout  wire  [VRAM_DW-1:0] DATA,
  output logic               nCE,
  output logic               nOE,
  output logic               nWE
);

  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_CYCLES - 1);

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [VRAM_AW-1:0] r_addr;
  logic [VRAM_DW-1:0] r_wdata;
  logic [VRAM_DW-1:0] r_rdata;
  logic               r_rvalid;
  strb_t              r_strb;
  logic               w_accept;
  logic               w_rd_done;

  assign READY     = (r_state == ST_IDLE);
  assign w_accept  = READY & REQ;
  assign w_rd_done = (r_state == ST_RD) && (r_cnt == '0);

  // Next-state and cycle-counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (REQ) begin
          w_state_nxt = RW ? ST_RD : ST_WR_SETUP;
          w_cnt_nxt   = RW ? RD_LOAD : '0;
        end
      end
      ST_RD: begin
        if (r_cnt == '0) w_state_nxt = ST_IDLE;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      ST_WR_SETUP: begin
        w_state_nxt = ST_WR_PULSE;
        w_cnt_nxt   = WR_LOAD;
      end
      ST_WR_PULSE: begin
        if (r_cnt == '0) w_state_nxt = ST_WR_HOLD;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      ST_WR_HOLD: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // State, counter and registered pin strobes; reset parks the bus immediately.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_strb  <= STRB_IDLE;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_strb  <= strb_of(w_state_nxt);
    end
  end

  // Address and write data are captured only on acceptance.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_addr  <= REQ_ADDR;
      r_wdata <= WDATA;
    end
  end

  // Read data capture on the last RD edge, with a single-cycle valid pulse.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_rd_done;
      if (w_rd_done) r_rdata <= DATA;
    end
  end

  assign DATA        = r_strb.doe ? r_wdata : {VRAM_DW{1'bz}};
  assign ADDR        = r_addr;
  assign RDATA       = r_rdata;
  assign RDATA_VALID = r_rvalid;
  assign nCE         = r_strb.nce;
  assign nOE         = r_strb.noe;
  assign nWE         = r_strb.nwe;

endmodule

// File: tb/tb_vram_fast_ctrl.sv
// Self-checking bench for vram_fast_ctrl: directed handshake/timing cases,
// async reset mid-write, then randomized traffic against a memory model.
module tb_vram_fast_ctrl;
  import vram_ctrl_pkg::*;

  localparam int RDC = 2;
  localparam int WRC = 1;

  logic        CLK = 1'b0;
  logic        nRESET;
  logic        REQ;
  logic        RW;
  logic [10:0] REQ_ADDR;
  logic [7:0]  WDATA;
  logic        READY, RDATA_VALID, nCE, nOE, nWE;
  logic [7:0]  RDATA;
  logic [10:0] ADDR;
  wire  [7:0]  DATA;

  vram_fast_ctrl #(.RD_CYCLES(RDC), .WR_CYCLES(WRC)) dut (
    .CLK(CLK), .nRESET(nRESET), .REQ(REQ), .RW(RW), .REQ_ADDR(REQ_ADDR),
    .WDATA(WDATA), .READY(READY), .RDATA(RDATA), .RDATA_VALID(RDATA_VALID),
    .ADDR(ADDR), .DATA(DATA), .nCE(nCE), .nOE(nOE), .nWE(nWE)
  );

  always #21 CLK = ~CLK;

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Asynchronous SRAM load: drives on read, latches on the rising nWE edge.
  logic [7:0] mem [2048];
  assign DATA = (!nCE && !nOE && nWE) ? mem[ADDR] : 8'bz;
  always @(posedge nWE) if (!nCE && nRESET) mem[ADDR] <= DATA;

  // Reference contents: what each address must read back as.
  logic [7:0] exp_mem   [2048];
  bit         exp_known [2048];
  logic [7:0] last_rd;

  // Bus-safety monitor: no output-enable overlap with drive or write, bus
  // turnaround gaps in both directions, valid never two cycles in a row.
  bit   mon_en = 0;
  logic prev_doe = 0, prev_oe = 0, prev_vld = 0;
  always @(negedge CLK) begin
    if (mon_en) begin
      chk("oe_vs_drive", 32'(!nOE && (dut.r_strb.doe || !nWE)), 0);
      chk("turn_wr_rd", 32'(!nOE && prev_doe), 0);
      chk("turn_rd_wr", 32'(dut.r_strb.doe && prev_oe), 0);
      chk("vld_pulse", 32'(RDATA_VALID && prev_vld), 0);
    end
    prev_doe <= dut.r_strb.doe;
    prev_oe  <= !nOE;
    prev_vld <= RDATA_VALID;
  end

  initial begin
    #(42 * 90000);
    $display("FAIL watchdog timeout errors=%0d", errs);
    $fatal(1, "watchdog");
  end

  task automatic wait_ready();
    for (int i = 0; i < 40; i++) begin
      if (READY) return;
      @(negedge CLK);
    end
    chk("ready_timeout", 0, 1);
  endtask

  task automatic do_write(input logic [10:0] a, input logic [7:0] d);
    int nwe_low;
    int rdy_at;
    wait_ready();
    REQ = 1; RW = 0; REQ_ADDR = a; WDATA = d;
    @(posedge CLK);
    @(negedge CLK);
    REQ = 0; REQ_ADDR = 11'($urandom); WDATA = 8'($urandom);
    nwe_low = 0; rdy_at = -1;
    for (int k = 0; k <= WRC + 3; k++) begin
      chk("wr_addr", 32'(ADDR), 32'(a));
      chk("wr_nwe", 32'(nWE), 32'(!(k >= 1 && k <= WRC)));
      chk("wr_nce", 32'(nCE), 32'(k >= 2 + WRC));
      if (!nWE) nwe_low++;
      if (READY) begin rdy_at = k; break; end
      @(negedge CLK);
    end
    chk("wr_nwe_len", 32'(nwe_low), 32'(WRC));
    chk("wr_ready_at", 32'(rdy_at), 32'(2 + WRC));
    exp_mem[a]   = d;
    exp_known[a] = 1;
  endtask

  task automatic do_read(input logic [10:0] a);
    wait_ready();
    REQ = 1; RW = 1; REQ_ADDR = a;
    @(posedge CLK);
    @(negedge CLK);
    REQ = 0; REQ_ADDR = 11'($urandom);
    for (int k = 0; k <= RDC; k++) begin
      chk("rd_addr", 32'(ADDR), 32'(a));
      chk("rd_vld", 32'(RDATA_VALID), 32'(k == RDC));
      chk("rd_ready", 32'(READY), 32'(k >= RDC));
      chk("rd_noe", 32'(nOE), 32'(k >= RDC));
      if (k == RDC) begin
        if (exp_known[a]) begin
          chk("rd_data", 32'(RDATA), 32'(exp_mem[a]));
          last_rd = exp_mem[a];
        end
      end else begin
        @(negedge CLK);
      end
    end
  endtask

  initial begin
    int vcnt;
    logic [10:0] a;
    for (int i = 0; i < 2048; i++) begin
      mem[i]       = 8'($urandom);
      exp_mem[i]   = mem[i];
      exp_known[i] = 1;
    end
    last_rd = 8'h00;
    nRESET = 0; REQ = 0; RW = 0; REQ_ADDR = '0; WDATA = '0;
    repeat (3) @(negedge CLK);

    // Reset then idle.
    chk("rst_ready", 32'(READY), 1);
    chk("rst_strobes", 32'({nCE, nOE, nWE}), 32'(3'b111));
    chk("rst_drive", 32'(dut.r_strb.doe), 0);
    chk("rst_rdata", 32'(RDATA), 0);
    chk("rst_vld", 32'(RDATA_VALID), 0);
    chk("rst_addr", 32'(ADDR), 0);
    nRESET = 1;
    @(negedge CLK);
    chk("idle_strobes", 32'({nCE, nOE, nWE, READY}), 32'(4'b1111));
    mon_en = 1;

    // Write 0xA5 to 0x123, read it back.
    do_write(11'h123, 8'hA5);
    do_read(11'h123);

    // Back-to-back reads with REQ held high.
    do_write(11'h000, 8'h3C);
    do_write(11'h7FF, 8'hC3);
    wait_ready();
    REQ = 1; RW = 1; REQ_ADDR = 11'h000;
    @(posedge CLK);
    @(negedge CLK);
    REQ_ADDR = 11'h7FF;
    vcnt = 0;
    for (int k = 0; k <= 2 * RDC + 3; k++) begin
      chk("b2b_addr", 32'(ADDR), (k <= RDC) ? 32'h000 : 32'h7FF);
      chk("b2b_vld", 32'(RDATA_VALID), 32'(k == RDC || k == 2 * RDC + 1));
      if (RDATA_VALID) vcnt++;
      if (k == RDC) chk("b2b_data0", 32'(RDATA), 32'h3C);
      if (k == 2 * RDC + 1) chk("b2b_data1", 32'(RDATA), 32'hC3);
      if (k == RDC + 1) REQ = 0;
      @(negedge CLK);
    end
    chk("b2b_pulses", 32'(vcnt), 2);
    last_rd = 8'hC3;

    // REQ pulsed during RD with another address and a write is ignored.
    do_write(11'h055, 8'h11);
    do_write(11'h2AA, 8'h22);
    wait_ready();
    REQ = 1; RW = 1; REQ_ADDR = 11'h055;
    @(posedge CLK);
    @(negedge CLK);
    REQ = 1; RW = 0; REQ_ADDR = 11'h2AA; WDATA = 8'h99;
    for (int k = 0; k <= RDC; k++) begin
      chk("ign_addr", 32'(ADDR), 32'h055);
      chk("ign_vld", 32'(RDATA_VALID), 32'(k == RDC));
      if (k == RDC) chk("ign_data", 32'(RDATA), 32'h11);
      else @(negedge CLK);
      if (k == 0) REQ = 0;
    end
    last_rd = 8'h11;
    do_read(11'h2AA);

    // Async reset in the middle of WR_PULSE.
    wait_ready();
    REQ = 1; RW = 0; REQ_ADDR = 11'h3A0; WDATA = 8'h77;
    @(posedge CLK);
    @(negedge CLK);
    REQ = 0;
    @(negedge CLK);
    chk("rst_pre_nwe", 32'(nWE), 0);
    mon_en = 0;
    #5 nRESET = 0;
    #1;
    chk("arst_strobes", 32'({nCE, nOE, nWE}), 32'(3'b111));
    chk("arst_drive", 32'(dut.r_strb.doe), 0);
    chk("arst_ready", 32'(READY), 1);
    chk("arst_addr", 32'(ADDR), 0);
    chk("arst_rdata", 32'(RDATA), 0);
    exp_known[11'h3A0] = 0;
    last_rd = 8'h00;
    @(negedge CLK);
    nRESET = 1;
    @(negedge CLK);
    mon_en = 1;
    chk("post_rst_ready", 32'(READY), 1);
    do_read(11'h123);

    // Randomized traffic.
    for (int n = 0; n < 10000; n++) begin
      chk("rdata_hold", 32'(RDATA), 32'(last_rd));
      a = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(0, 2047)) : 11'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 0 || !exp_known[a]) do_write(a, 8'($urandom));
      else do_read(a);
    end

    repeat (2) @(negedge CLK);
    mon_en = 0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
